// File: rtl/sd_pkg.sv
// Shared definitions for the SD command/response path: FSM states,
// CRC7 polynomial and frame geometry.
package sd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CRC,
        END,
        GAP
    } state_t;

    localparam logic [6:0]  SD_CRC7_POLY     = 7'h09;
    localparam int unsigned SD_CMD_FRAME_W   = 48;
    localparam int unsigned SD_CMD_PAYLOAD_W = 40;

endpackage

// File: rtl/sd_crc7_step.sv
// One-bit CRC7 update (x^7 + x^3 + 1), MSB-first. Shared with the
// response-path checker.
module sd_crc7_step
    import sd_pkg::*;
(
    input  logic [6:0] crc_in,
    input  logic       bit_in,
    output logic [6:0] crc_next
);

    logic fb;

    // Feedback is the incoming bit XOR the CRC MSB; fold in the polynomial.
    always_comb begin
        fb       = bit_in ^ crc_in[6];
        crc_next = {crc_in[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
    end

endmodule

// File: rtl/sd_cmd_serializer.sv
// Host-side SD command framer: latches index/argument, shifts the 48-bit
// CMD frame out MSB first and appends CRC7 computed on the fly.
// Optional macro SD_CMD_NCC_EN adds an NCC_CYCLES idle gap after each frame.
module sd_cmd_serializer
    import sd_pkg::*;
`ifdef SD_CMD_NCC_EN
#(
    parameter int unsigned NCC_CYCLES = 8
)
`endif
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        busy,
    output logic        done,
    output logic        cmd_out,
    output logic        cmd_oe,
    output logic [6:0]  crc_out
);

    localparam int unsigned CRC_BITS = SD_CMD_FRAME_W - SD_CMD_PAYLOAD_W - 1;

    state_t                      state, state_nxt;
    logic [SD_CMD_PAYLOAD_W-1:0] shreg;
    logic [5:0]                  cnt;
    logic [6:0]                  crc;
    logic [6:0]                  crc_step;

`ifdef SD_CMD_NCC_EN
    localparam int unsigned GAP_W = (NCC_CYCLES > 1) ? $clog2(NCC_CYCLES) : 1;
    logic [GAP_W-1:0] gap_cnt;
`endif

    sd_crc7_step u_crc7_step (
        .crc_in   (crc),
        .bit_in   (shreg[SD_CMD_PAYLOAD_W-1]),
        .crc_next (crc_step)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and combinational pad/busy outputs.
    always_comb begin
        state_nxt = state;
        cmd_out   = 1'b1;
        cmd_oe    = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = SHIFT;
            end
            SHIFT: begin
                cmd_out = shreg[SD_CMD_PAYLOAD_W-1];
                cmd_oe  = 1'b1;
                if (cnt == 6'd0) state_nxt = CRC;
            end
            CRC: begin
                cmd_out = crc[cnt[2:0]];
                cmd_oe  = 1'b1;
                if (cnt == 6'd0) state_nxt = END;
            end
            END: begin
                cmd_oe = 1'b1;
`ifdef SD_CMD_NCC_EN
                state_nxt = GAP;
`else
                state_nxt = IDLE;
`endif
            end
            GAP: begin
`ifdef SD_CMD_NCC_EN
                if (gap_cnt == '0) state_nxt = IDLE;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: frame shifter, bit counter, running CRC, result and done.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shreg   <= '0;
            cnt     <= '0;
            crc     <= '0;
            crc_out <= '0;
            done    <= 1'b0;
`ifdef SD_CMD_NCC_EN
            gap_cnt <= '0;
`endif
        end else begin
            done <= (state == END);
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= {2'b01, cmd_index, cmd_arg};
                        crc   <= '0;
                        cnt   <= 6'(SD_CMD_PAYLOAD_W - 1);
                    end
                end
                SHIFT: begin
                    shreg <= shreg << 1;
                    crc   <= crc_step;
                    cnt   <= (cnt == 6'd0) ? 6'(CRC_BITS - 1) : cnt - 6'd1;
                end
                CRC: begin
                    if (cnt != 6'd0) cnt <= cnt - 6'd1;
                end
                END: begin
                    crc_out <= crc;
`ifdef SD_CMD_NCC_EN
                    gap_cnt <= GAP_W'(NCC_CYCLES - 1);
`endif
                end
                GAP: begin
`ifdef SD_CMD_NCC_EN
                    if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_serializer.sv
// Self-checking bench for sd_cmd_serializer: directed frames, scoreboard of
// expected 48-bit frames/CRCs, ignored start, mid-frame reset, back-to-back.
module tb_sd_cmd_serializer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        busy, done, cmd_out, cmd_oe;
    logic [6:0]  crc_out;

    always #5 CLK = ~CLK;

    sd_cmd_serializer dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .cmd_index (cmd_index),
        .cmd_arg   (cmd_arg),
        .busy      (busy),
        .done      (done),
        .cmd_out   (cmd_out),
        .cmd_oe    (cmd_oe),
        .crc_out   (crc_out)
    );

`ifdef SD_CMD_NCC_EN
    localparam int SPACING = 57;
`else
    localparam int SPACING = 49;
`endif

    typedef struct packed {
        logic [47:0] frame;
        logic [6:0]  crc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc, nbits, done_cnt, done_cyc, rise_cnt, rise1, rise2, low_cnt;
    logic [47:0] bits;
    logic [6:0]  pend_crc;
    logic        prev_oe;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    // Advance n cycles, sampling at each falling edge.
    task automatic run_cycles(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            cyc++;
            if (cmd_oe === 1'b1) begin
                if (prev_oe !== 1'b1) begin
                    rise_cnt++;
                    if (rise_cnt == 1) rise1 = cyc;
                    else if (rise_cnt == 2) rise2 = cyc;
                end
                bits = {bits[46:0], cmd_out};
                nbits++;
                if (nbits == 48) begin
                    nbits = 0;
                    chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("frame", 64'(bits), 64'(e.frame));
                        pend_crc = e.crc;
                    end
                end
            end else if (rise_cnt == 1) begin
                low_cnt++;
            end
            prev_oe = cmd_oe;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_busy", 64'(busy), 64'd0);
                chk("done_oe", 64'(cmd_oe), 64'd0);
                chk("crc_out", 64'(crc_out), 64'(pend_crc));
            end
        end
    endtask

    // Present a command at a falling edge; the following rising edge is N.
    task automatic accept(input logic [5:0] idx, input logic [31:0] arg,
                          input logic [6:0] c, input bit hold);
        exp_t e;
        e.frame = {2'b01, idx, arg, c, 1'b1};
        e.crc   = c;
        sb.push_back(e);
        start     = 1'b1;
        cmd_index = idx;
        cmd_arg   = arg;
        @(posedge CLK);
        cyc = 0; done_cnt = 0; done_cyc = -1;
        rise_cnt = 0; low_cnt = 0; nbits = 0;
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic single(input string name, input logic [5:0] idx,
                          input logic [31:0] arg, input logic [6:0] c);
        accept(idx, arg, c, 1'b0);
        run_cycles(60);
        chk({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({name, "_done_cyc"}, 64'(done_cyc), 64'd49);
        chk({name, "_sb_drained"}, 64'(sb.size()), 64'd0);
        chk({name, "_idle_oe"}, 64'(cmd_oe), 64'd0);
        chk({name, "_idle_out"}, 64'(cmd_out), 64'd1);
    endtask

    logic [5:0]  ridx;
    logic [31:0] rarg;

    initial begin
        RST = 1'b1; start = 1'b0; cmd_index = '0; cmd_arg = '0;
        prev_oe = 1'b0; pend_crc = '0; bits = '0;
        cyc = 0; nbits = 0; done_cnt = 0; done_cyc = -1;
        rise_cnt = 0; rise1 = 0; rise2 = 0; low_cnt = 0;
        repeat (3) @(negedge CLK);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_out", 64'(cmd_out), 64'd1);
        chk("rst_oe", 64'(cmd_oe), 64'd0);
        chk("rst_crc", 64'(crc_out), 64'd0);
        RST = 1'b0;
        run_cycles(2);

        single("cmd0", 6'd0, 32'h0000_0000, 7'h4A);
        single("cmd17", 6'h11, 32'h0000_0000, 7'h2A);
        single("cmd8", 6'd8, 32'h0000_01AA, 7'h43);

        ridx = 6'($urandom_range(0, 63));
        rarg = $urandom;
        single("rand", ridx, rarg, crc7({2'b01, ridx, rarg}));

        // start pulse during a busy frame must be ignored
        accept(6'd0, 32'h0, 7'h4A, 1'b0);
        run_cycles(20);
        start = 1'b1;
        run_cycles(1);
        start = 1'b0;
        run_cycles(60);
        chk("ign_done_cnt", 64'(done_cnt), 64'd1);
        chk("ign_done_cyc", 64'(done_cyc), 64'd49);
        chk("ign_sb_drained", 64'(sb.size()), 64'd0);
        chk("ign_one_frame", 64'(rise_cnt), 64'd1);

        // load a non-zero crc_out so the reset clear is visible
        single("pre_rst", 6'd8, 32'h0000_01AA, 7'h43);
        accept(6'd0, 32'h0, 7'h4A, 1'b0);
        sb.delete();
        run_cycles(30);
        RST = 1'b1;
        #1;
        chk("midrst_oe", 64'(cmd_oe), 64'd0);
        chk("midrst_out", 64'(cmd_out), 64'd1);
        chk("midrst_crc", 64'(crc_out), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        nbits = 0; prev_oe = 1'b0; done_cnt = 0;
        run_cycles(60);
        chk("midrst_no_done", 64'(done_cnt), 64'd0);
        single("post_rst", 6'd0, 32'h0, 7'h4A);

        // start held high: back-to-back frames
        sb.push_back('{frame: {2'b01, 6'd8, 32'h0000_01AA, 7'h43, 1'b1}, crc: 7'h43});
        accept(6'd8, 32'h0000_01AA, 7'h43, 1'b1);
        run_cycles(SPACING);
        run_cycles(1);
        start = 1'b0;
        run_cycles(60);
        chk("b2b_rises", 64'(rise_cnt), 64'd2);
        chk("b2b_spacing", 64'(rise2 - rise1), 64'(SPACING));
        chk("b2b_gap_low", 64'(low_cnt), 64'(SPACING - 48));
        chk("b2b_done_cnt", 64'(done_cnt), 64'd2);
        chk("b2b_sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
